// File: rtl/pipe_flush_sched_pkg.sv
// Shared constants for the pipeline flush scheduler: exception codes, stall bit map, FSM encodings.
// Purely declarative; no logic, no latency, no backpressure.
package pipe_flush_sched_pkg;

   localparam int          EXCEPT_BUS_W   = 32;
   localparam logic [31:0] EXC_ERET       = 32'h0000_000e;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // A stage stall freezes its own register and everything upstream of it.
   localparam logic [5:0] STALL_VEC_MEM = 6'b011111;
   localparam logic [5:0] STALL_VEC_EX  = 6'b001111;
   localparam logic [5:0] STALL_VEC_ID  = 6'b000111;
   localparam logic [5:0] STALL_VEC_IF  = 6'b000011;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   function automatic logic [5:0] stall_bit(input int idx);
      logic [5:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/pipe_flush_sched_stall_prio_enc.sv
// Priority encoder from per-stage stall requests to the 6-bit stall vector (mem > ex > id > if).
// Combinational, zero latency; no backpressure.
module stall_prio_enc
   import pipe_flush_sched_pkg::*;
(
   input  logic       i_req_if,
   input  logic       i_req_id,
   input  logic       i_req_ex,
   input  logic       i_req_mem,
   output logic [5:0] o_stall
);

   always_comb begin
      o_stall = '0;
      if (i_req_mem)
         o_stall = STALL_VEC_MEM;
      else if (i_req_ex)
         o_stall = STALL_VEC_EX;
      else if (i_req_id)
         o_stall = STALL_VEC_ID;
      else if (i_req_if)
         o_stall = STALL_VEC_IF;
   end

endmodule

// File: rtl/pipe_flush_sched.sv
// Merges stage stall requests and sequences exception/ERET flushes, deferring the PC redirect past an outstanding fetch.
// Flush is same-cycle; redirect is same-cycle or N+1 cycles behind a busy fetch; stalls hold pc/if while draining.
module pipe_flush_sched
   import pipe_flush_sched_pkg::*;
#(
   parameter int          EXC_W      = EXCEPT_BUS_W,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic [EXC_W-1:0] except_type,
   input  logic [31:0]      cp0_epc,
   input  logic             inst_busy,
   output logic [5:0]       stall,
   output logic             flush,
   output logic             redirect,
   output logic [31:0]      new_pc,
   output logic             discard_inst,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [31:0]      r_tgt;
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;
   logic [5:0]       w_enc_stall;
   logic             w_exc;
   logic             w_accept;
   logic [31:0]      w_tgt;

   stall_prio_enc u_stall_prio_enc (
      .i_req_if  (stallreq_if),
      .i_req_id  (stallreq_id),
      .i_req_ex  (stallreq_ex),
      .i_req_mem (stallreq_mem),
      .o_stall   (w_enc_stall)
   );

   assign w_exc    = (except_type != '0);
   assign w_tgt    = (except_type == EXC_W'(EXC_ERET)) ? cp0_epc : EXC_VECTOR;
   assign w_accept = !rst && (r_state == S_IDLE) && w_exc;

   always_comb begin
      stall        = '0;
      flush        = 1'b0;
      redirect     = 1'b0;
      new_pc       = '0;
      discard_inst = 1'b0;
      w_state_nxt  = r_state;
      if (!rst) begin
         if (r_state == S_IDLE) begin
            if (w_exc) begin
               flush = 1'b1;
               if (!inst_busy) begin
                  redirect = 1'b1;
                  new_pc   = w_tgt;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end else begin
               stall = w_enc_stall;
            end
         end else begin
            // Pipeline is already empty here, so new exceptions and stage stalls are ignored.
            stall = stall_bit(STALL_PC) | stall_bit(STALL_IF);
            if (!inst_busy) begin
               redirect    = 1'b1;
               new_pc      = r_tgt;
               w_state_nxt = S_IDLE;
            end else begin
               discard_inst = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_tgt          <= '0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_tgt <= w_tgt;
            if (r_flush_count != '1)
               r_flush_count <= r_flush_count + 1'b1;
         end
         if ((stall != '0) && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign stall_cycles = rst ? '0 : r_stall_cycles;
   assign flush_count  = rst ? '0 : r_flush_count;

endmodule

// File: tb/tb_pipe_flush_sched.sv
// Directed bench for pipe_flush_sched: reset, stall priority, ERET/exception flushes, drain and reset-in-drain.
module tb_pipe_flush_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic [31:0] except_type;
   logic [31:0] cp0_epc;
   logic        inst_busy;
   logic [5:0]  stall;
   logic        flush, redirect, discard_inst;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles, flush_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_flush_sched dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .except_type  (except_type),
      .cp0_epc      (cp0_epc),
      .inst_busy    (inst_busy),
      .stall        (stall),
      .flush        (flush),
      .redirect     (redirect),
      .new_pc       (new_pc),
      .discard_inst (discard_inst),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 1;
      except_type = 32'd1; cp0_epc = 32'h1111_2222; inst_busy = 1'b0;
      settle();
      chk("rst_stall", {26'd0, stall}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_new_pc", new_pc, 32'd0);
      chk("rst_discard", {31'd0, discard_inst}, 32'd0);
      step(); step();
      chk("rst_flush_cnt_held", flush_count, 32'd0);

      rst = 1'b0; stallreq_mem = 0; except_type = 0;
      settle();
      chk("idle_stall_cycles", stall_cycles, 32'd0);
      chk("idle_flush_count", flush_count, 32'd0);
      chk("idle_stall", {26'd0, stall}, 32'd0);

      stallreq_if = 1; stallreq_ex = 1;
      settle();
      chk("prio_ex_over_if", {26'd0, stall}, 32'h0000_000f);
      step();
      chk("stall_cnt_1", stall_cycles, 32'd1);
      stallreq_ex = 0;
      settle();
      chk("prio_if_only", {26'd0, stall}, 32'h0000_0003);
      step();
      chk("stall_cnt_2", stall_cycles, 32'd2);
      stallreq_if = 0; stallreq_id = 1; stallreq_mem = 1;
      settle();
      chk("prio_mem_over_id", {26'd0, stall}, 32'h0000_001f);
      stallreq_mem = 0;
      settle();
      chk("prio_id_only", {26'd0, stall}, 32'h0000_0007);
      step();
      stallreq_id = 0;
      settle();
      chk("stall_cnt_3", stall_cycles, 32'd3);

      // ERET with no fetch outstanding: flush and redirect in the same cycle
      except_type = 32'h0000_000e; cp0_epc = 32'h8000_1234; inst_busy = 0;
      settle();
      chk("eret_flush", {31'd0, flush}, 32'd1);
      chk("eret_redirect", {31'd0, redirect}, 32'd1);
      chk("eret_new_pc", new_pc, 32'h8000_1234);
      chk("eret_stall", {26'd0, stall}, 32'd0);
      step();
      except_type = 0;
      settle();
      chk("eret_flush_count", flush_count, 32'd1);
      chk("eret_stall_cycles", stall_cycles, 32'd3);
      chk("idle_new_pc_zero", new_pc, 32'd0);

      // Exception while a fetch is outstanding for three more cycles
      except_type = 32'd1; inst_busy = 1;
      settle();
      chk("exc_busy_flush", {31'd0, flush}, 32'd1);
      chk("exc_busy_redirect", {31'd0, redirect}, 32'd0);
      chk("exc_busy_stall", {26'd0, stall}, 32'd0);
      step();
      except_type = 0;
      settle();
      chk("drain1_discard", {31'd0, discard_inst}, 32'd1);
      chk("drain1_stall", {26'd0, stall}, 32'h0000_0003);
      chk("drain1_flush", {31'd0, flush}, 32'd0);
      chk("drain1_flush_count", flush_count, 32'd2);
      step();
      except_type = 32'd1; stallreq_mem = 1;
      settle();
      chk("drain2_second_exc_flush", {31'd0, flush}, 32'd0);
      chk("drain2_stall_ignores_req", {26'd0, stall}, 32'h0000_0003);
      chk("drain2_discard", {31'd0, discard_inst}, 32'd1);
      step();
      except_type = 0; stallreq_mem = 0;
      settle();
      chk("drain3_flush_count", flush_count, 32'd2);
      chk("drain3_discard", {31'd0, discard_inst}, 32'd1);
      step();
      inst_busy = 0;
      settle();
      chk("drain_exit_redirect", {31'd0, redirect}, 32'd1);
      chk("drain_exit_new_pc", new_pc, 32'hBFC0_0380);
      chk("drain_exit_discard", {31'd0, discard_inst}, 32'd0);
      chk("drain_exit_stall_cycles", stall_cycles, 32'd6);
      step();
      settle();
      chk("post_drain_redirect", {31'd0, redirect}, 32'd0);
      chk("post_drain_stall_cycles", stall_cycles, 32'd7);

      // Exception and memory stall together: flush wins
      except_type = 32'd1; stallreq_mem = 1;
      settle();
      chk("exc_stall_flush", {31'd0, flush}, 32'd1);
      chk("exc_stall_stall", {26'd0, stall}, 32'd0);
      chk("exc_stall_new_pc", new_pc, 32'hBFC0_0380);
      step();
      except_type = 0; stallreq_mem = 0;
      settle();
      chk("exc_stall_flush_count", flush_count, 32'd3);
      chk("exc_stall_stall_cycles", stall_cycles, 32'd7);

      // Reset asserted while draining cancels the pending redirect
      except_type = 32'd1; inst_busy = 1;
      step();
      except_type = 0;
      settle();
      chk("rd_drain_discard", {31'd0, discard_inst}, 32'd1);
      rst = 1;
      settle();
      chk("rd_rst_discard", {31'd0, discard_inst}, 32'd0);
      chk("rd_rst_stall", {26'd0, stall}, 32'd0);
      step();
      rst = 0;
      settle();
      chk("rd_idle_discard", {31'd0, discard_inst}, 32'd0);
      chk("rd_idle_stall", {26'd0, stall}, 32'd0);
      chk("rd_flush_count", flush_count, 32'd0);
      chk("rd_stall_cycles", stall_cycles, 32'd0);
      step();
      inst_busy = 0;
      settle();
      chk("rd_no_redirect", {31'd0, redirect}, 32'd0);
      chk("rd_no_new_pc", new_pc, 32'd0);
      step();
      settle();
      chk("rd_no_redirect_later", {31'd0, redirect}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
